// File: rtl/cla_subtractor_pkg.sv
// Shared definitions for the pipelined carry-lookahead subtractor.
// Holds the default operand width and the stage-1 pipeline record layout.
package cla_pkg;

   localparam int CLA_WIDTH = 8;

   // Stage-1 record at the default width: propagate/generate vectors,
   // the inverted borrow-in (carry into bit 0), both operand sign bits and valid.
   typedef struct packed {
      logic [CLA_WIDTH-1:0] p;
      logic [CLA_WIDTH-1:0] g;
      logic                 c0;
      logic                 a_msb;
      logic                 b_msb;
      logic                 valid;
   } stage1_t;

endpackage

// File: rtl/cla_subtractor_if.sv
// Operand/result handshake bundle for cla_subtractor.
// master = upstream producer and downstream consumer side, slave = the subtractor.
interface cla_subtractor_if
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] minuend;
   logic [WIDTH-1:0] subtrahend;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;

   modport master (
      output in_valid, minuend, subtrahend, bin, out_ready,
      input  in_ready, out_valid, diff, bout, ovf
   );

   modport slave (
      input  in_valid, minuend, subtrahend, bin, out_ready,
      output in_ready, out_valid, diff, bout, ovf
   );

endinterface

// File: rtl/cla_carry_gen.sv
// Purely combinational carry-lookahead network.
// Every carry is formed directly as a sum of products of g, p and c0, so no
// carry depends on a previously computed carry.
module cla_carry_gen
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
) (
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] g,
   input  logic             c0,
   output logic [WIDTH:0]   c
);

   // Flattened lookahead: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c0
   always_comb begin
      logic acc;
      logic prop;
      c    = '0;
      c[0] = c0;
      for (int i = 0; i < WIDTH; i++) begin
         acc  = g[i];
         prop = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            acc  = acc | (prop & g[j]);
            prop = prop & p[j];
         end
         acc      = acc | (prop & c0);
         c[i + 1] = acc;
      end
   end

endmodule

// File: rtl/cla_subtractor.sv
// Three-stage pipelined subtractor computing A - B - bin as A + ~B + ~bin
// with a carry-lookahead network, plus borrow-out and signed overflow.
// Optional macro CLA_SUBTRACTOR_SATURATE_EN clamps diff to zero on borrow.
module cla_subtractor
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
) (
   input logic             clk,
   input logic             reset,
   cla_subtractor_if.slave bus
);

   // Stage-1 record sized to this instance's width; same layout as cla_pkg::stage1_t.
   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] g;
      logic             c0;
      logic             a_msb;
      logic             b_msb;
      logic             valid;
   } stage1_rec_t;

   logic             en;
   stage1_rec_t      s1;
   logic [WIDTH:0]   cNext;
   logic [WIDTH:0]   s2Carry;
   logic [WIDTH-1:0] s2P;
   logic             s2AMsb;
   logic             s2BMsb;
   logic             s2Valid;
   logic [WIDTH-1:0] sumRaw;
   logic [WIDTH-1:0] diffNext;
   logic             boutNext;
   logic             ovfNext;
   logic [WIDTH-1:0] s3Diff;
   logic             s3Bout;
   logic             s3Ovf;
   logic             s3Valid;

   // One global enable: the whole pipe moves unless a result is waiting unclaimed.
   assign en            = !s3Valid || bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = s3Valid;
   assign bus.diff      = s3Diff;
   assign bus.bout      = s3Bout;
   assign bus.ovf       = s3Ovf;

   // Stage 1: form generate/propagate for A + ~B and the carry-in ~bin.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
      end else if (en) begin
         s1.valid <= bus.in_valid;
         s1.p     <= bus.minuend ^ ~bus.subtrahend;
         s1.g     <= bus.minuend & ~bus.subtrahend;
         s1.c0    <= ~bus.bin;
         s1.a_msb <= bus.minuend[WIDTH-1];
         s1.b_msb <= bus.subtrahend[WIDTH-1];
      end
   end

   cla_carry_gen #(
      .WIDTH (WIDTH)
   ) u_carry_gen (
      .p  (s1.p),
      .g  (s1.g),
      .c0 (s1.c0),
      .c  (cNext)
   );

   // Stage 2: capture the lookahead carries; sign bits ride along for overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2Carry <= '0;
         s2P     <= '0;
         s2AMsb  <= 1'b0;
         s2BMsb  <= 1'b0;
         s2Valid <= 1'b0;
      end else if (en) begin
         s2Carry <= cNext;
         s2P     <= s1.p;
         s2AMsb  <= s1.a_msb;
         s2BMsb  <= s1.b_msb;
         s2Valid <= s1.valid;
      end
   end

   // Final sum, borrow and overflow; overflow looks at the unclamped sum bit.
   always_comb begin
      sumRaw   = s2P ^ s2Carry[WIDTH-1:0];
      boutNext = ~s2Carry[WIDTH];
      ovfNext  = (s2AMsb != s2BMsb) && (sumRaw[WIDTH-1] != s2AMsb);
`ifdef CLA_SUBTRACTOR_SATURATE_EN
      diffNext = boutNext ? '0 : sumRaw;
`else
      diffNext = sumRaw;
`endif
   end

   // Stage 3: output register, frozen while a result waits for out_ready.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s3Diff  <= '0;
         s3Bout  <= 1'b0;
         s3Ovf   <= 1'b0;
         s3Valid <= 1'b0;
      end else if (en) begin
         s3Diff  <= diffNext;
         s3Bout  <= boutNext;
         s3Ovf   <= ovfNext;
         s3Valid <= s2Valid;
      end
   end

endmodule

// File: tb/tb_cla_subtractor.sv
// Self-checking bench for cla_subtractor: directed vector table, stall,
// mid-flight reset, and randomized traffic on 8- and 16-bit instances
// checked against an arithmetic scoreboard model.
module tb_cla_subtractor;
   import cla_pkg::*;

`ifdef CLA_SUBTRACTOR_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int NUM_RAND = 10000;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;

   cla_subtractor_if #(.WIDTH(8))  bus8 ();
   cla_subtractor_if #(.WIDTH(16)) bus16 ();

   cla_subtractor #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   cla_subtractor #(.WIDTH(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
      logic       ov;
   } vec_t;

   vec_t vecs[8];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic bin);
      bus8.in_valid   = 1'b1;
      bus8.minuend    = a;
      bus8.subtrahend = b;
      bus8.bin        = bin;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Plain-arithmetic reference: {ovf, bout, diff[15:0]} for a w-bit subtraction.
   function automatic logic [17:0] refModel(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin);
      longint modv, half, ua, ub, full, sa, sb, sres;
      logic [15:0] d;
      logic bo, ov;
      modv = longint'(1) << w;
      half = modv >> 1;
      ua   = longint'(a);
      ub   = longint'(b);
      full = ua - ub - longint'(bin);
      bo   = (full < 0);
      d    = 16'(bo ? full + modv : full);
      sa   = (ua >= half) ? ua - modv : ua;
      sb   = (ub >= half) ? ub - modv : ub;
      sres = sa - sb - longint'(bin);
      ov   = (sres < -half) || (sres >= half);
      if (SAT && bo) d = '0;
      return {ov, bo, d};
   endfunction

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0]  expDiff;
      logic [7:0]  streamExp[3];
      logic [17:0] q8[$];
      logic [17:0] q16[$];
      logic [17:0] expRec;
      logic [17:0] gotRec;
      logic [15:0] ra, rb;
      logic        rbin;
      int          got;
      int          stale;
      int          sent8, sent16, done8, done16, cycles;

      compared   = 0;
      mismatched = 0;

      vecs[0] = '{"sub_50_30",   8'h50, 8'h30, 1'b0, 8'h20, 1'b0, 1'b0};
      vecs[1] = '{"sub_10_20",   8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
      vecs[2] = '{"sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[3] = '{"sub_80_01",   8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      vecs[4] = '{"sub_7f_ff",   8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      vecs[5] = '{"sub_ff_ff_b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{"sub_00_ff",   8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
      vecs[7] = '{"sub_aa_55_b", 8'hAA, 8'h55, 1'b1, 8'h54, 1'b0, 1'b1};

      reset            = 1'b0;
      bus8.in_valid    = 1'b0;
      bus8.minuend     = '0;
      bus8.subtrahend  = '0;
      bus8.bin         = 1'b0;
      bus8.out_ready   = 1'b1;
      bus16.in_valid   = 1'b0;
      bus16.minuend    = '0;
      bus16.subtrahend = '0;
      bus16.bin        = 1'b0;
      bus16.out_ready  = 1'b1;

      // Reset state
      #3;
      checkOutput("reset_out_valid", 64'(bus8.out_valid), 64'd0);
      checkOutput("reset_in_ready",  64'(bus8.in_ready),  64'd1);
      checkOutput("reset_diff",      64'(bus8.diff),      64'd0);
      checkOutput("reset_bout",      64'(bus8.bout),      64'd0);
      checkOutput("reset_ovf",       64'(bus8.ovf),       64'd0);
      tick();
      tick();
      reset = 1'b1;
      tick();

      // Directed vectors, one at a time, checking exact 3-cycle latency
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin);
         tick();
         bus8.in_valid = 1'b0;
         tick();
         checkOutput({vecs[i].name, "_early"}, 64'(bus8.out_valid), 64'd0);
         tick();
         expDiff = (SAT && vecs[i].bo) ? 8'h00 : vecs[i].d;
         checkOutput({vecs[i].name, "_valid"}, 64'(bus8.out_valid), 64'd1);
         checkOutput({vecs[i].name, "_diff"},  64'(bus8.diff),      64'(expDiff));
         checkOutput({vecs[i].name, "_bout"},  64'(bus8.bout),      64'(vecs[i].bo));
         checkOutput({vecs[i].name, "_ovf"},   64'(bus8.ovf),       64'(vecs[i].ov));
         tick();
         checkOutput({vecs[i].name, "_nodup"}, 64'(bus8.out_valid), 64'd0);
      end

      // Back-to-back stream with a 4-cycle output stall
      bus8.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'(5 + k), 8'h01, 1'b0);
         tick();
      end
      bus8.in_valid = 1'b0;
      checkOutput("stall_first_valid", 64'(bus8.out_valid), 64'd1);
      for (int k = 0; k < 4; k++) begin
         checkOutput("stall_in_ready", 64'(bus8.in_ready), 64'd0);
         checkOutput("stall_diff",     64'(bus8.diff),     64'h04);
         tick();
      end
      streamExp[0] = 8'h04;
      streamExp[1] = 8'h05;
      streamExp[2] = 8'h06;
      bus8.out_ready = 1'b1;
      got = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus8.out_valid) begin
            if (got < 3) checkOutput("stream_order", 64'(bus8.diff), 64'(streamExp[got]));
            got++;
         end
         tick();
      end
      checkOutput("stream_count", 64'(got), 64'd3);

      // Mid-flight reset with one result waiting and one behind it
      bus8.out_ready = 1'b0;
      applyStimulus(8'h20, 8'h01, 1'b0);
      tick();
      applyStimulus(8'h30, 8'h01, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      tick();
      checkOutput("rst_pre_valid", 64'(bus8.out_valid), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rst_async_valid", 64'(bus8.out_valid), 64'd0);
      checkOutput("rst_async_ready", 64'(bus8.in_ready),  64'd1);
      checkOutput("rst_async_diff",  64'(bus8.diff),      64'd0);
      tick();
      reset = 1'b1;
      bus8.out_ready = 1'b1;
      stale = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus8.out_valid) stale++;
      end
      checkOutput("rst_no_stale", 64'(stale), 64'd0);
      applyStimulus(8'h09, 8'h02, 1'b0);
      tick();
      bus8.in_valid = 1'b0;
      tick();
      tick();
      checkOutput("rst_after_valid", 64'(bus8.out_valid), 64'd1);
      checkOutput("rst_after_diff",  64'(bus8.diff),      64'h07);
      tick();

      // Randomized traffic on both widths against the scoreboard model
      sent8 = 0; sent16 = 0; done8 = 0; done16 = 0; cycles = 0;
      while ((done8 < NUM_RAND || done16 < NUM_RAND) && cycles < 60000) begin
         bus8.in_valid    = (sent8 < NUM_RAND) && ($urandom_range(3) != 0);
         bus8.minuend     = 8'($urandom);
         bus8.subtrahend  = 8'($urandom);
         bus8.bin         = 1'($urandom);
         bus8.out_ready   = ($urandom_range(3) != 0);
         bus16.in_valid   = (sent16 < NUM_RAND) && ($urandom_range(3) != 0);
         bus16.minuend    = 16'($urandom);
         bus16.subtrahend = 16'($urandom);
         bus16.bin        = 1'($urandom);
         bus16.out_ready  = ($urandom_range(3) != 0);
         @(negedge clk);
         if (bus8.out_valid && bus8.out_ready) begin
            gotRec = {bus8.ovf, bus8.bout, 8'h00, bus8.diff};
            if (q8.size() == 0) begin
               checkOutput("rand8_extra", 64'd1, 64'd0);
            end else begin
               expRec = q8.pop_front();
               checkOutput("rand8_result", 64'(gotRec), 64'(expRec));
            end
            done8++;
         end
         if (bus8.in_valid && bus8.in_ready) begin
            ra = {8'h00, bus8.minuend};
            rb = {8'h00, bus8.subtrahend};
            rbin = bus8.bin;
            q8.push_back(refModel(8, ra, rb, rbin));
            sent8++;
         end
         if (bus16.out_valid && bus16.out_ready) begin
            gotRec = {bus16.ovf, bus16.bout, bus16.diff};
            if (q16.size() == 0) begin
               checkOutput("rand16_extra", 64'd1, 64'd0);
            end else begin
               expRec = q16.pop_front();
               checkOutput("rand16_result", 64'(gotRec), 64'(expRec));
            end
            done16++;
         end
         if (bus16.in_valid && bus16.in_ready) begin
            q16.push_back(refModel(16, bus16.minuend, bus16.subtrahend, bus16.bin));
            sent16++;
         end
         tick();
         cycles++;
      end
      checkOutput("rand8_count",  64'(done8),  64'(NUM_RAND));
      checkOutput("rand16_count", 64'(done16), 64'(NUM_RAND));
      checkOutput("rand8_left",   64'(q8.size()),  64'd0);
      checkOutput("rand16_left",  64'(q16.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/cla_subtractor.md
CLA_SUBTRACTOR -- requirements
Module: cla_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting operand and result width in bits (minimum 2).
REQ-002 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset  input  1: asynchronous, active-low reset; reset low SHALL clear state immediately, independent of clk.
REQ-004 Port in_valid  input  1: the operand set presented this cycle is valid.
REQ-005 Port in_ready  output  1: the block accepts the operand set this cycle.
REQ-006 Port minuend  input  WIDTH: operand A.
REQ-007 Port subtrahend  input  WIDTH: operand B.
REQ-008 Port bin  input  1: borrow-in.
REQ-009 Port out_valid  output  1: the result set is valid.
REQ-010 Port out_ready  input  1: the downstream block takes the result this cycle.
REQ-011 Port diff  output  WIDTH: the result A - B - bin, modulo 2^WIDTH.
REQ-012 Port bout  output  1: borrow-out, high when A < B + bin in unsigned terms.
REQ-013 Port ovf  output  1: signed two's-complement overflow of the subtraction.

Function
REQ-014 Arithmetic SHALL be A + ~B + ~bin using carry-lookahead: g = A & ~B, p = A ^ ~B, c[0] = ~bin, c[i+1] = g[i] | p[i]&c[i].
REQ-015 Stage 1 SHALL register p, g, c[0], A[WIDTH-1], B[WIDTH-1] and a valid bit.
REQ-016 Stage 2 SHALL compute the lookahead carries c[WIDTH:0] from stage-1 registers and register them with p and a valid bit.
REQ-017 Stage 3 SHALL register diff = p ^ c[WIDTH-1:0], bout = ~c[WIDTH], ovf = (A msb != B msb) && (diff msb != A msb), and out_valid.
REQ-018 Latency SHALL be exactly 3 cycles from an accepted input (in_valid && in_ready) to out_valid, when there is no stall.
REQ-019 Global advance enable SHALL be en = !out_valid || out_ready; in_ready SHALL equal en.
REQ-020 When en is low, all three stages SHALL hold their contents, and diff, bout and ovf SHALL stay stable while out_valid is high.
REQ-021 Bubbles SHALL propagate as valid=0 and SHALL NOT be collapsed; throughput SHALL be 1 result per cycle without backpressure.
REQ-022 When in_valid is low and en is high, stage 1 SHALL load valid=0; its data registers may update.
REQ-023 Results SHALL leave in acceptance order, with none lost or duplicated under any out_ready pattern.
REQ-024 When the output is taken and a new input is accepted in the same cycle, both SHALL succeed.

Reset
REQ-025 While reset is low, all valid bits, out_valid, diff, bout and ovf SHALL be 0; in_ready SHALL be 1.
REQ-026 A reset asserted mid-operation SHALL discard every in-flight operation; no result SHALL emerge after release.
REQ-027 Reset release SHALL be usable synchronously; the first input accepted after release SHALL be handled normally.

Configuration
REQ-028 Macro CLA_SUBTRACTOR_SATURATE_EN, when defined, SHALL force stage-3 diff to 0 whenever bout=1; bout and ovf SHALL be unaffected.
REQ-029 Without CLA_SUBTRACTOR_SATURATE_EN, diff SHALL be the plain modulo-2^WIDTH result.

Structure
REQ-030 Shared package cla_pkg SHALL hold the default width constant CLA_WIDTH=8 and the typedef of the stage-1 record (p, g, c0, a_msb, b_msb, valid).
REQ-031 One sub-module, cla_carry_gen, SHALL hold the purely combinational lookahead carry network (inputs p, g, c0; output c[WIDTH:0]), instantiated in stage 2.

Verification
REQ-032 0x50 - 0x30, bin=0, out_ready=1 -> 3 cycles later diff=0x20, bout=0, ovf=0.
REQ-033 0x10 - 0x20, bin=0 -> diff=0xF0 (0x00 with SATURATE_EN), bout=1, ovf=0; 0x00 - 0x00, bin=1 -> diff=0xFF (0x00 with SATURATE_EN), bout=1.
REQ-034 0x80 - 0x01 -> diff=0x7F, bout=0, ovf=1; 0x7F - 0xFF -> diff=0x80, bout=1, ovf=1.
REQ-035 Stream 0x05-0x01, 0x06-0x01, 0x07-0x01 back-to-back; hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 and diff held at 0x04; after release, outputs 0x04, 0x05, 0x06 in order, none lost.
REQ-036 Assert reset low with 2 operations in flight -> out_valid=0 immediately and no stale result after release; the next input 0x09-0x02 -> diff=0x07.
REQ-037 Randomised 10k operations with random in_valid/out_ready, WIDTH=8 and WIDTH=16 -> every result matches the scoreboard model, in order.
